// File: rtl/mem_bist_pkg.sv
// Shared definitions for the March-style memory self-test initiator.
//   BIST_ADDR_W / BIST_DATA_W : default memory geometry (16x8)
//   DEPTH / ERR_W             : memory depth and error-counter width for the default geometry
//   BIST_PATTERN              : default background pattern; its complement is written second
//   bist_state_t              : test sequencer states (Idle, W0, R0, W1, R1, R1 drain, Done)
package mem_bist_pkg;

  localparam int unsigned BIST_ADDR_W = 4;
  localparam int unsigned BIST_DATA_W = 8;
  localparam int unsigned DEPTH       = 2 ** BIST_ADDR_W;
  localparam int unsigned ERR_W       = BIST_ADDR_W + 2;

  localparam logic [BIST_DATA_W-1:0] BIST_PATTERN = 8'h55;

  typedef enum logic [2:0] {
    StIdle,
    StW0,
    StR0,
    StW1,
    StR1,
    StR1Drain,
    StDone
  } bist_state_t;

endpackage

// File: rtl/mem_bist_checker.sv
// Read-data comparator for the memory self-test.
// Compares read data against the expected value whenever a compare is valid, keeps a
// saturating mismatch count and records the address of the first mismatch.
// Ports:
//   clk_i, rst_i         : clock, synchronous active-high reset
//   clr_i                : clears count and first-fail address (accepted start)
//   vld_i, exp_i, dat_i  : compare strobe, expected data, memory read data
//   addr_i               : address the read data belongs to
//   hit_o                : combinational mismatch flag for the current cycle
//   err_count_o          : saturating mismatch count
//   fail_addr_o          : address of the first mismatch since the last clear
module mem_bist_checker #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] exp_i,
  input  logic [DATA_W-1:0] dat_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [ADDR_W+1:0] err_count_o,
  output logic [ADDR_W-1:0] fail_addr_o
);

  localparam int unsigned ErrW = ADDR_W + 2;

  logic [ErrW-1:0]   err_count_q, err_count_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;

  assign hit_o = vld_i && (dat_i != exp_i);

  always_comb begin
    err_count_d = err_count_q;
    fail_addr_d = fail_addr_q;
    if (clr_i) begin
      err_count_d = '0;
      fail_addr_d = '0;
    end else if (hit_o) begin
      // Zero count means this is the first mismatch of the run.
      if (err_count_q == '0) begin
        fail_addr_d = addr_i;
      end
      if (err_count_q != {ErrW{1'b1}}) begin
        err_count_d = err_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_count_q <= '0;
      fail_addr_q <= '0;
    end else begin
      err_count_q <= err_count_d;
      fail_addr_q <= fail_addr_d;
    end
  end

  assign err_count_o = err_count_q;
  assign fail_addr_o = fail_addr_q;

endmodule

// File: rtl/mem_bist_master.sv
// March-style self-test initiator for a single-port synchronous-read memory.
// Sequence: write PATTERN ascending; read/verify PATTERN then write ~PATTERN per address
// ascending; read/verify ~PATTERN descending, compared one cycle later through a pipeline.
// Optional build macro MEM_BIST_STOP_ON_FAIL_EN: the first mismatch ends the test on the
// next cycle with no further writes. Undefined: every mismatch is counted to completion.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (aborts a running test)
//   start           : one-cycle request, accepted only when idle or done
//   busy, done      : test running / test finished (held until the next accepted start)
//   pass            : valid with done, 1 when no mismatch was seen
//   err_count       : saturating mismatch count
//   fail_addr       : address of the first mismatch
//   adr, dat_w, we  : memory request port (registered)
//   dat_r           : memory read data, reflects the address registered on the previous edge
module mem_bist_master
  import mem_bist_pkg::*;
#(
  parameter int unsigned        ADDR_W  = BIST_ADDR_W,
  parameter int unsigned        DATA_W  = BIST_DATA_W,
  parameter logic [DATA_W-1:0]  PATTERN = BIST_PATTERN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W+1:0] err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [ADDR_W-1:0] adr,
  output logic [DATA_W-1:0] dat_w,
  output logic              we,
  input  logic [DATA_W-1:0] dat_r
);

  bist_state_t       state_q, state_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_w_q, dat_w_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  // Descending-read compare pipeline: data for the address issued last cycle.
  logic              r1_vld_q, r1_vld_d;
  logic [ADDR_W-1:0] r1_adr_q, r1_adr_d;

  logic              start_ok;
  logic              chk_vld;
  logic [DATA_W-1:0] chk_exp;
  logic [ADDR_W-1:0] chk_adr;
  logic              hit;
  logic              stop;
  logic              finish;

  assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));

  // In W1, dat_r holds the pre-write contents of adr (issued by R0), checked against PATTERN.
  assign chk_vld = (state_q == StW1) || r1_vld_q;
  assign chk_exp = (state_q == StW1) ? PATTERN : ~PATTERN;
  assign chk_adr = (state_q == StW1) ? adr_q : r1_adr_q;

  mem_bist_checker #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_checker (
    .clk_i       (clk),
    .rst_i       (rst),
    .clr_i       (start_ok),
    .vld_i       (chk_vld),
    .exp_i       (chk_exp),
    .dat_i       (dat_r),
    .addr_i      (chk_adr),
    .hit_o       (hit),
    .err_count_o (err_count),
    .fail_addr_o (fail_addr)
  );

`ifdef MEM_BIST_STOP_ON_FAIL_EN
  assign stop = hit;
`else
  assign stop = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    dat_w_d  = dat_w_q;
    we_d     = 1'b0;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    r1_vld_d = 1'b0;
    r1_adr_d = r1_adr_q;
    finish   = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StW0;
          adr_d   = '0;
          dat_w_d = PATTERN;
          we_d    = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      StW0: begin
        if (adr_q == '1) begin
          state_d = StR0;
          adr_d   = '0;
        end else begin
          adr_d = adr_q + 1'b1;
          we_d  = 1'b1;
        end
      end
      StR0: begin
        state_d = StW1;
        we_d    = 1'b1;
        dat_w_d = ~PATTERN;
      end
      StW1: begin
        if (adr_q == '1) begin
          state_d = StR1;
        end else begin
          state_d = StR0;
          adr_d   = adr_q + 1'b1;
        end
      end
      StR1: begin
        r1_vld_d = 1'b1;
        r1_adr_d = adr_q;
        if (adr_q == '0) begin
          state_d = StR1Drain;
        end else begin
          adr_d = adr_q - 1'b1;
        end
      end
      StR1Drain: begin
        finish = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (stop) begin
      finish   = 1'b1;
      r1_vld_d = 1'b0;
    end

    if (finish) begin
      state_d = StDone;
      we_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      // Include a mismatch seen in this same cycle, not yet in err_count.
      pass_d  = (err_count == '0) && !hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      adr_q    <= '0;
      dat_w_q  <= '0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      r1_vld_q <= 1'b0;
      r1_adr_q <= '0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      dat_w_q  <= dat_w_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      r1_vld_q <= r1_vld_d;
      r1_adr_q <= r1_adr_d;
    end
  end

  assign adr   = adr_q;
  assign dat_w = dat_w_q;
  assign we    = we_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign pass  = pass_q;

endmodule

// File: tb/tb_mem_bist_master.sv
// Bench for mem_bist_master: a 16x8 memory with injectable faults, a functional March model
// that predicts error count / first-fail address / end cycle, and a per-cycle monitor that
// checks the request stream and status outputs against the expected operation schedule.
// Fault kinds: 0 none, 1 stuck bit at f_a (bit f_b forced to f_v[0] on read),
// 2 word at f_a reads as f_v, 3 decoder alias (writes to f_a also land on f_b, reads of
// f_a return cell f_b).
module tb_mem_bist_master;

  localparam logic [7:0] P  = 8'h55;
  localparam logic [7:0] NP = 8'hAA;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, pass, we;
  logic [5:0] err_count;
  logic [3:0] fail_addr, adr;
  logic [7:0] dat_w, dat_r;

  always #5 clk = ~clk;

  mem_bist_master #(
    .ADDR_W  (4),
    .DATA_W  (8),
    .PATTERN (8'h55)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_addr (fail_addr),
    .adr       (adr),
    .dat_w     (dat_w),
    .we        (we),
    .dat_r     (dat_r)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got, want);
    end
  endtask

  // ---------------- fault configuration and memories ----------------
  int         f_kind = 0;
  int         f_a = 0;
  int         f_b = 0;
  logic [7:0] f_v = 8'h00;

  logic [7:0] dmem     [16];
  logic [7:0] fmem     [16];
  logic [7:0] init_mem [16];
  logic       ld = 1'b0;

  function automatic int phys(input int r);
    return (f_kind == 3 && r == f_a) ? f_b : r;
  endfunction

  function automatic logic [7:0] rd_xf(input int r, input logic [7:0] v);
    logic [7:0] o;
    o = v;
    if (f_kind == 1 && r == f_a) o[f_b] = f_v[0];
    if (f_kind == 2 && r == f_a) o = f_v;
    return o;
  endfunction

  // Single port: the address registered for reading is the one being written.
  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 16; i++) dmem[i] <= init_mem[i];
    end else if (we) begin
      dmem[adr] <= dat_w;
      if (f_kind == 3 && int'(adr) == f_a) dmem[f_b] <= dat_w;
    end
    dat_r <= rd_xf(int'(adr), we ? dat_w : dmem[phys(int'(adr))]);
  end

  // ---------------- functional March model ----------------
  int m_err, m_fa, m_end;
  bit m_stopped;

  task automatic f_wr(input int w, input logic [7:0] v);
    fmem[w] = v;
    if (f_kind == 3 && w == f_a) fmem[f_b] = v;
  endtask

  task automatic note(input int a, input int cyc);
    if (m_err == 0) m_fa = a;
    if (m_err < 63) m_err++;
`ifdef MEM_BIST_STOP_ON_FAIL_EN
    if (!m_stopped) m_end = cyc + 1;
    m_stopped = 1'b1;
`else
    if (cyc < 0) m_end = 0;
`endif
  endtask

  // Detection cycles counted from the start edge: R0 check of a in cycle 18+2a,
  // descending check of a in cycle 65-a; done normally from cycle 66.
  task automatic model_run();
    logic [7:0] v;
    m_err = 0; m_fa = 0; m_end = 66; m_stopped = 1'b0;
    for (int i = 0; i < 16; i++) fmem[i] = init_mem[i];
    for (int a = 0; a < 16; a++) f_wr(a, P);
    for (int a = 0; a < 16; a++) begin
      if (!m_stopped) begin
        v = rd_xf(a, fmem[phys(a)]);
        f_wr(a, NP);
        if (v != P) note(a, 18 + 2 * a);
      end
    end
    for (int a = 15; a >= 0; a--) begin
      if (!m_stopped) begin
        v = rd_xf(a, fmem[phys(a)]);
        if (v != NP) note(a, 65 - a);
      end
    end
  endtask

  // ---------------- per-cycle monitor ----------------
  bit mon_on = 1'b0;
  int mon_k  = 0;
  int e_adr, e_we, e_dw;

  task automatic exp_op(input int k, output int ea, output int ew, output int ed);
    int j;
    ea = 0; ew = 0; ed = 0;
    if (k <= 16) begin
      ea = k - 1; ew = 1; ed = int'(P);
    end else if (k <= 48) begin
      j = k - 17; ea = j / 2; ew = j % 2; ed = int'(NP);
    end else begin
      ea = 15 - (k - 49);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      mon_k++;
      if (mon_k < m_end) begin
        chk("busy_run", int'(busy), 1);
        chk("done_run", int'(done), 0);
        chk("pass_run", int'(pass), 0);
        if (mon_k <= 64) begin
          exp_op(mon_k, e_adr, e_we, e_dw);
          chk("adr", int'(adr), e_adr);
          chk("we", int'(we), e_we);
          if (e_we != 0) chk("dat_w", int'(dat_w), e_dw);
        end else begin
          chk("we_drain", int'(we), 0);
        end
      end else begin
        chk("busy_end", int'(busy), 0);
        chk("done_end", int'(done), 1);
        chk("we_end", int'(we), 0);
        chk("err_count", int'(err_count), m_err);
        chk("fail_addr", int'(fail_addr), m_fa);
        chk("pass_end", int'(pass), (m_err == 0) ? 1 : 0);
      end
    end
  end

  // ---------------- test sequencing ----------------
  task automatic load_mem();
    for (int i = 0; i < 16; i++) init_mem[i] = 8'($urandom_range(0, 255));
    @(posedge clk); #1 ld = 1'b1;
    @(posedge clk); #1 ld = 1'b0;
  endtask

  task automatic kick();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    mon_k  = 0;
    mon_on = 1'b1;
  endtask

  task automatic run_test(input bit mid_start);
    int bad;
    load_mem();
    model_run();
    kick();
    for (int c = 0; c < m_end + 3; c++) begin
      @(posedge clk); #1;
      start = mid_start && (c == 29);
    end
    start  = 1'b0;
    mon_on = 1'b0;
    bad = 0;
    for (int i = 0; i < 16; i++) if (dmem[i] !== fmem[i]) bad++;
    chk("mem_contents", bad, 0);
  endtask

  initial begin
    int bad;
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_we", int'(we), 0);
    chk("rst_err", int'(err_count), 0);
    chk("rst_adr", int'(adr), 0);
    rst = 1'b0;

    // Fault-free: clean pass, memory ends all complement.
    f_kind = 0;
    run_test(1'b0);
    chk("pin_clean_err", m_err, 0);
    chk("clean_pass", int'(pass), 1);
    bad = 0;
    for (int i = 0; i < 16; i++) if (dmem[i] !== 8'hAA) bad++;
    chk("clean_mem_aa", bad, 0);

    // Address 5 bit 0 stuck-at-1: only the descending read fails.
    f_kind = 1; f_a = 5; f_b = 0; f_v = 8'h01;
    run_test(1'b0);
    chk("pin_sb_err", m_err, 1);
    chk("sb_err", int'(err_count), 1);
    chk("sb_fa", int'(fail_addr), 5);
    chk("sb_pass", int'(pass), 0);

    // Address 3 stuck at 0: fails both reads (stops after the first in stop mode).
    f_kind = 2; f_a = 3; f_v = 8'h00;
    run_test(1'b0);
`ifdef MEM_BIST_STOP_ON_FAIL_EN
    chk("pin_sw_err", m_err, 1);
    chk("sw_err", int'(err_count), 1);
`else
    chk("pin_sw_err", m_err, 2);
    chk("sw_err", int'(err_count), 2);
`endif
    chk("sw_fa", int'(fail_addr), 3);

    // Decoder alias 9 -> 1.
    f_kind = 3; f_a = 9; f_b = 1;
    run_test(1'b0);
    chk("pin_al_fa", m_fa, 9);
    chk("al_fa", int'(fail_addr), 9);
    chk("al_err_nz", (err_count != 0) ? 1 : 0, 1);

    // Reset mid-test aborts immediately.
    f_kind = 0;
    load_mem();
    model_run();
    kick();
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    mon_on = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_pass", int'(pass), 0);
    chk("abort_err", int'(err_count), 0);
    chk("abort_fa", int'(fail_addr), 0);
    chk("abort_adr", int'(adr), 0);
    chk("abort_dat_w", int'(dat_w), 0);
    chk("abort_we", int'(we), 0);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_we_after", int'(we), 0);
    end

    // Clean run with a start pulse while busy; length must be unchanged.
    run_test(1'b1);
    chk("midstart_pass", int'(pass), 1);

    // Randomized faults.
    for (int t = 0; t < 12; t++) begin
      f_kind = $urandom_range(0, 3);
      f_a = $urandom_range(0, 15);
      f_b = (f_kind == 3) ? ((f_a + $urandom_range(1, 15)) % 16) : $urandom_range(0, 7);
      f_v = 8'($urandom_range(0, 255));
      run_test(($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
